// File: rtl/counter_pkg.sv
// Shared BCD counter definitions: digit type, digit limits and preset sanitising.
package counter_pkg;

   localparam int unsigned BCD_DIGIT_W = 4;

   typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   // Non-decimal nibbles clamp to 9 so the count never leaves valid BCD.
   function automatic bcd_digit_t sanitize_digit(input bcd_digit_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_down_counter_if.sv
// Control/data bundle for bcd_down_counter; master drives load/enable, slave returns the count.
interface bcd_down_counter_if
   import counter_pkg::*;
#(
   parameter int unsigned DIGITS = 4
);
   localparam int unsigned W = BCD_DIGIT_W * DIGITS;

   logic         enable;
   logic         load;
   logic [W-1:0] load_value;
   logic [W-1:0] count;
   logic         zero;
   logic         done;

   modport master (
      output enable, load, load_value,
      input  count, zero, done
   );

   modport slave (
      input  enable, load, load_value,
      output count, zero, done
   );
endinterface

// File: rtl/bcd_down_digit.sv
// Single BCD digit cell: loads a digit, or steps down by one (0 wraps to 9) on borrow.
module bcd_down_digit
   import counter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  bcd_digit_t load_digit,
   input  logic       borrow_in,
   output bcd_digit_t digit,
   output logic       is_zero
);

   always_ff @(posedge clk) begin
      if (reset) begin
         digit <= '0;
      end else if (load) begin
         digit <= load_digit;
      end else if (borrow_in) begin
         digit <= (digit == '0) ? BCD_MAX : digit - bcd_digit_t'(1);
      end
   end

   assign is_zero = (digit == '0);

endmodule

// File: rtl/bcd_down_counter.sv
// Cascaded BCD down counter with zero flag and done pulse on reaching zero.
// Build option BCD_DOWN_COUNTER_AUTO_RELOAD_EN: enable at zero reloads the preset instead of saturating.
module bcd_down_counter
   import counter_pkg::*;
#(
   parameter int unsigned DIGITS = 4
)(
   input  logic             clk,
   input  logic             reset,
   bcd_down_counter_if.slave bus
);

   localparam int unsigned W = BCD_DIGIT_W * DIGITS;

   logic [W-1:0]      count_w;
   logic [W-1:0]      preset;
   logic [W-1:0]      load_clean;
   logic [DIGITS-1:0] is_zero;
   logic [DIGITS-1:0] borrow;
   logic              zero_w;
   logic              dec;
   logic              reload;
   logic              cell_load;
   logic              done_q;
   logic              done_d;

   assign zero_w = &is_zero;
   assign dec    = bus.enable & ~bus.load & ~zero_w;

`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
   assign reload = bus.enable & ~bus.load & zero_w;
`else
   assign reload = 1'b0;
`endif

   assign cell_load = bus.load | reload;

   // Digit cells; borrow ripples up through a prefix-AND of lower zero flags.
   for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
      bcd_digit_t cell_digit;
      bcd_digit_t cell_load_digit;

      assign load_clean[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
         sanitize_digit(bus.load_value[i*BCD_DIGIT_W +: BCD_DIGIT_W]);

      assign cell_load_digit = bus.load ? load_clean[i*BCD_DIGIT_W +: BCD_DIGIT_W]
                                        : preset[i*BCD_DIGIT_W +: BCD_DIGIT_W];

      if (i == 0) begin : g_lsd
         assign borrow[i] = dec;
      end else begin : g_upper
         assign borrow[i] = borrow[i-1] & is_zero[i-1];
      end

      bcd_down_digit u_digit (
         .clk        (clk),
         .reset      (reset),
         .load       (cell_load),
         .load_digit (cell_load_digit),
         .borrow_in  (borrow[i]),
         .digit      (cell_digit),
         .is_zero    (is_zero[i])
      );

      assign count_w[i*BCD_DIGIT_W +: BCD_DIGIT_W] = cell_digit;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         preset <= '0;
      end else if (bus.load) begin
         preset <= load_clean;
      end
   end

   // Pulse only when a decrement steps 0..01 down to zero.
   always_comb begin
      done_d = 1'b0;
      if (dec && (count_w == W'(1))) begin
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end

   assign bus.count = count_w;
   assign bus.zero  = zero_w;
   assign bus.done  = done_q;

endmodule
